// File: rtl/pit_seq_if.sv
// pit_seq_if: register-write, control and status bundle for the interval timer.
// Carries ovr only when PIT_IRQ_LATCH_EN is defined.
`default_nettype none

interface pit_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             pre_wr;
  logic [WIDTH-1:0] pre_din;
  logic             div_wr;
  logic [WIDTH-1:0] div_din;
  logic             enable;
  logic             oneshot;
  logic             irq_ack;
  logic [WIDTH-1:0] pre_q;
  logic [WIDTH-1:0] div_q;
  logic             running;
  logic             tick;
  logic             irq;
`ifdef PIT_IRQ_LATCH_EN
  logic             ovr;
`endif

  modport master (
    output pre_wr, pre_din, div_wr, div_din, enable, oneshot, irq_ack,
`ifdef PIT_IRQ_LATCH_EN
    input  ovr,
`endif
    input  pre_q, div_q, running, tick, irq
  );

  modport slave (
    input  pre_wr, pre_din, div_wr, div_din, enable, oneshot, irq_ack,
`ifdef PIT_IRQ_LATCH_EN
    output ovr,
`endif
    output pre_q, div_q, running, tick, irq
  );
endinterface

`default_nettype wire

// File: rtl/pit_seq.sv
// +--------------------------------------------------------------------------+
// | pit_seq : prescaler + divider interval timer sequencer (periodic/one-shot)|
// | Optional macro PIT_IRQ_LATCH_EN: sticky irq with ack and overrun flag.     |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module pit_seq #(
  parameter int WIDTH = 16
) (
  input  wire logic  clk,
  input  wire logic  reset,
  pit_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pre_rld, div_rld, pre_rld_n, div_rld_n;
  logic [WIDTH-1:0] pre_cnt, div_cnt, pre_cnt_n, div_cnt_n;
  logic             tick_r;
  logic             tc_event;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pre_rld <= '0;
      div_rld <= '0;
      pre_cnt <= '0;
      div_cnt <= '0;
      tick_r  <= 1'b0;
    end else begin
      state   <= state_n;
      pre_rld <= pre_rld_n;
      div_rld <= div_rld_n;
      pre_cnt <= pre_cnt_n;
      div_cnt <= div_cnt_n;
      tick_r  <= tc_event;
    end
  end

  always_comb begin
    // A write landing on a reload edge must be the value that gets reloaded.
    pre_rld_n = bus.pre_wr ? bus.pre_din : pre_rld;
    div_rld_n = bus.div_wr ? bus.div_din : div_rld;
    state_n   = state;
    pre_cnt_n = pre_cnt;
    div_cnt_n = div_cnt;
    tc_event  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          pre_cnt_n = pre_rld_n;
          div_cnt_n = div_rld_n;
          state_n   = RUN;
        end else begin
          if (bus.pre_wr) pre_cnt_n = bus.pre_din;
          if (bus.div_wr) div_cnt_n = bus.div_din;
        end
      end
      RUN: begin
        if (!bus.enable) begin
          state_n = IDLE;
        end else if (pre_cnt != '0) begin
          pre_cnt_n = pre_cnt - WIDTH'(1);
        end else begin
          pre_cnt_n = pre_rld_n;
          if (div_cnt != '0) begin
            div_cnt_n = div_cnt - WIDTH'(1);
          end else begin
            div_cnt_n = div_rld_n;
            tc_event  = 1'b1;
            if (bus.oneshot) state_n = HALT;
          end
        end
      end
      HALT: begin
        if (bus.pre_wr) pre_cnt_n = bus.pre_din;
        if (bus.div_wr) div_cnt_n = bus.div_din;
        if (!bus.enable) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.pre_q   = pre_cnt;
  assign bus.div_q   = div_cnt;
  assign bus.running = (state == RUN);
  assign bus.tick    = tick_r;

`ifdef PIT_IRQ_LATCH_EN
  logic irq_r, ovr_r;

  // A new event outranks a coincident acknowledge for both flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_r <= 1'b0;
      ovr_r <= 1'b0;
    end else begin
      irq_r <= tc_event | (irq_r & ~bus.irq_ack);
      ovr_r <= (tc_event & irq_r) | (ovr_r & ~bus.irq_ack);
    end
  end

  assign bus.irq = irq_r;
  assign bus.ovr = ovr_r;
`else
  assign bus.irq = tick_r;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pit_seq.sv
// tb_pit_seq: scoreboard bench for pit_seq; expected (pre_q,div_q,tick,irq,running)
// tuples are queued as stimulus is driven and compared one cycle later.
`default_nettype none

module tb_pit_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pit_seq_if #(.WIDTH(W)) bus ();
  pit_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [W-1:0] p;
    logic [W-1:0] d;
    logic         t;
    logic         i;
    logic         r;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Post-load trajectories for pre=2/div=1 and pre=1/div=2.
  localparam int BP[12] = '{1, 0, 2, 1, 0, 2, 1, 0, 2, 1, 0, 2};
  localparam int BD[12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
  localparam int OP[6]  = '{0, 1, 0, 1, 0, 1};
  localparam int OD[6]  = '{2, 1, 1, 0, 0, 2};
  // pre=3/div=1 with pre writes of 1 and 2 and a div write of 0 mid-run.
  localparam int MP[14] = '{2, 1, 0, 1, 0, 1, 0, 2, 1, 0, 2, 1, 0, 2};
  localparam int MD[14] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};

  function automatic exp_t observed();
    return {bus.pre_q, bus.div_q, bus.tick, bus.irq, bus.running};
  endfunction

  task automatic push(input int p, input int d, input bit t, input bit i, input bit r);
    exp_t e;
    e.p = p[W-1:0];
    e.d = d[W-1:0];
    e.t = t;
    e.i = i;
    e.r = r;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.pre_wr = 1'b0;
    bus.div_wr = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      quiet();
      case (k)
        0: begin
          reset = 1'b1; bus.enable = 1'b1;
          bus.pre_wr = 1'b1; bus.pre_din = 16'd7;
          push(0, 0, 0, 0, 0);
        end
        1: begin reset = 1'b0; bus.enable = 1'b0; push(0, 0, 0, 0, 0); end
        2: begin bus.enable = 1'b1; push(0, 0, 0, 0, 1); end
        3: push(0, 0, 1, 1, 1);
        default: begin bus.enable = 1'b0; push(0, 0, 0, 0, 0); end
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL reset[%0d] got {p,d,tick,irq,run}=%h exp=%h", k, observed(), e);
      end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    for (int k = 0; k < 22; k++) begin
      quiet();
      if (k == 0) begin
        bus.enable = 1'b0;
        bus.pre_wr = 1'b1; bus.pre_din = 16'd2;
        bus.div_wr = 1'b1; bus.div_din = 16'd1;
        push(2, 1, 0, 0, 0);
      end else if (k == 1) begin
        bus.enable = 1'b1; push(2, 1, 0, 0, 1);
      end else if (k < 19) begin
        push(BP[(k-2) % 12], BD[(k-2) % 12], (k == 7 || k == 13), (k == 7 || k == 13), 1);
      end else if (k == 19) begin
        bus.enable = 1'b0; push(0, 0, 0, 0, 0);   // would-be terminal edge
      end else if (k == 20) begin
        bus.enable = 1'b1; push(2, 1, 0, 0, 1);
      end else begin
        bus.enable = 1'b0; push(2, 1, 0, 0, 0);
      end
      step();
      e = sb.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL basic[%0d] got {p,d,tick,irq,run}=%h exp=%h", k, observed(), e);
      end
    end
  endtask

  task automatic test_zero();
    exp_t e;
    for (int k = 0; k < 7; k++) begin
      quiet();
      if (k == 0) begin
        bus.pre_wr = 1'b1; bus.pre_din = 16'd0;
        bus.div_wr = 1'b1; bus.div_din = 16'd0;
        push(0, 0, 0, 0, 0);
      end else if (k == 1) begin
        bus.enable = 1'b1; push(0, 0, 0, 0, 1);
      end else if (k < 6) begin
        push(0, 0, 1, 1, 1);
      end else begin
        bus.enable = 1'b0; push(0, 0, 0, 0, 0);
      end
      step();
      e = sb.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL zero[%0d] got {p,d,tick,irq,run}=%h exp=%h", k, observed(), e);
      end
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    for (int k = 0; k < 15; k++) begin
      quiet();
      if (k == 0) begin
        bus.pre_wr = 1'b1; bus.pre_din = 16'd1;
        bus.div_wr = 1'b1; bus.div_din = 16'd2;
        push(1, 2, 0, 0, 0);
      end else if (k == 1) begin
        bus.oneshot = 1'b1; bus.enable = 1'b1; push(1, 2, 0, 0, 1);
      end else if (k < 8) begin
        push(OP[k-2], OD[k-2], (k == 7), (k == 7), (k != 7));
      end else if (k == 8) begin
        push(1, 2, 0, 0, 0);
      end else if (k == 9) begin
        bus.div_wr = 1'b1; bus.div_din = 16'd4; push(1, 4, 0, 0, 0);
      end else if (k == 10) begin
        push(1, 4, 0, 0, 0);
      end else if (k == 11) begin
        bus.enable = 1'b0; push(1, 4, 0, 0, 0);
      end else if (k == 12) begin
        bus.enable = 1'b1; push(1, 4, 0, 0, 1);
      end else if (k == 13) begin
        push(0, 4, 0, 0, 1);
      end else begin
        bus.enable = 1'b0; bus.oneshot = 1'b0; push(0, 4, 0, 0, 0);
      end
      step();
      e = sb.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL oneshot[%0d] got {p,d,tick,irq,run}=%h exp=%h", k, observed(), e);
      end
    end
  endtask

  task automatic test_midwrite();
    exp_t e;
    for (int k = 0; k < 17; k++) begin
      quiet();
      if (k == 0) begin
        bus.pre_wr = 1'b1; bus.pre_din = 16'd3;
        bus.div_wr = 1'b1; bus.div_din = 16'd1;
        push(3, 1, 0, 0, 0);
      end else if (k == 1) begin
        bus.enable = 1'b1; push(3, 1, 0, 0, 1);
      end else if (k < 16) begin
        if (k == 3) begin bus.pre_wr = 1'b1; bus.pre_din = 16'd1; end
        if (k == 9) begin bus.pre_wr = 1'b1; bus.pre_din = 16'd2; end
        if (k == 12) begin bus.div_wr = 1'b1; bus.div_din = 16'd0; end
        push(MP[k-2], MD[k-2], (k == 7 || k == 12 || k == 15), (k == 7 || k == 12 || k == 15), 1);
      end else begin
        bus.enable = 1'b0; push(2, 0, 0, 0, 0);
      end
      step();
      e = sb.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL midwrite[%0d] got {p,d,tick,irq,run}=%h exp=%h", k, observed(), e);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      quiet();
      case (k)
        0: begin
          bus.pre_wr = 1'b1; bus.pre_din = 16'd5;
          bus.div_wr = 1'b1; bus.div_din = 16'd3;
          push(5, 3, 0, 0, 0);
        end
        1: begin bus.enable = 1'b1; push(5, 3, 0, 0, 1); end
        2: begin
          reset = 1'b1; bus.oneshot = 1'b1;
          bus.pre_wr = 1'b1; bus.pre_din = 16'd9;
          bus.div_wr = 1'b1; bus.div_din = 16'd9;
          push(0, 0, 0, 0, 0);
        end
        3: begin reset = 1'b0; bus.oneshot = 1'b0; push(0, 0, 0, 0, 1); end
        4: push(0, 0, 1, 1, 1);
        default: begin bus.enable = 1'b0; push(0, 0, 0, 0, 0); end
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL reset_mid[%0d] got {p,d,tick,irq,run}=%h exp=%h", k, observed(), e);
      end
    end
  endtask

`ifdef PIT_IRQ_LATCH_EN
  task automatic test_irq_latch();
    exp_t e;
    logic ovr_q[$];
    logic ovr_exp;
    for (int k = 0; k < 13; k++) begin
      quiet();
      case (k)
        0: begin reset = 1'b1; bus.irq_ack = 1'b0; push(0, 0, 0, 0, 0); ovr_q.push_back(1'b0); end
        1: begin
          reset = 1'b0;
          bus.pre_wr = 1'b1; bus.pre_din = 16'd0;
          bus.div_wr = 1'b1; bus.div_din = 16'd1;
          push(0, 1, 0, 0, 0); ovr_q.push_back(1'b0);
        end
        2:  begin bus.enable = 1'b1; push(0, 1, 0, 0, 1); ovr_q.push_back(1'b0); end
        3:  begin push(0, 0, 0, 0, 1); ovr_q.push_back(1'b0); end
        4:  begin push(0, 1, 1, 1, 1); ovr_q.push_back(1'b0); end
        5:  begin push(0, 0, 0, 1, 1); ovr_q.push_back(1'b0); end
        6:  begin push(0, 1, 1, 1, 1); ovr_q.push_back(1'b1); end
        7:  begin push(0, 0, 0, 1, 1); ovr_q.push_back(1'b1); end
        8:  begin bus.irq_ack = 1'b1; push(0, 1, 1, 1, 1); ovr_q.push_back(1'b1); end
        9:  begin push(0, 0, 0, 0, 1); ovr_q.push_back(1'b0); end
        10: begin bus.irq_ack = 1'b0; push(0, 1, 1, 1, 1); ovr_q.push_back(1'b0); end
        11: begin bus.enable = 1'b0; push(0, 1, 0, 1, 0); ovr_q.push_back(1'b0); end
        default: begin bus.irq_ack = 1'b1; push(0, 1, 0, 0, 0); ovr_q.push_back(1'b0); end
      endcase
      step();
      e = sb.pop_front();
      ovr_exp = ovr_q.pop_front();
      checks++;
      if (observed() !== e || bus.ovr !== ovr_exp) begin
        failures++;
        $display("FAIL irq_latch[%0d] got {p,d,tick,irq,run}=%h ovr=%b exp=%h ovr=%b",
                 k, observed(), bus.ovr, e, ovr_exp);
      end
    end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    bus.pre_wr  = 1'b0;
    bus.pre_din = '0;
    bus.div_wr  = 1'b0;
    bus.div_din = '0;
    bus.enable  = 1'b0;
    bus.oneshot = 1'b0;
    bus.irq_ack = 1'b1;
    test_reset();
    test_basic();
    test_zero();
    test_oneshot();
    test_midwrite();
    test_reset_mid();
`ifdef PIT_IRQ_LATCH_EN
    test_irq_latch();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/pit_seq.md
Name: pit_seq

Overview:
- Programmable interval timer sequencer in the Tom system-control area.
- Controls a two-stage down-counter chain: a WIDTH-bit prescaler feeding a WIDTH-bit divider.
- Holds the reload registers, sequences load, decrement, borrow and reload, and generates a periodic or one-shot tick and interrupt request to the interrupt controller.

Parameters:
- WIDTH, 16, bit width of prescaler, divider and reload registers.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pre_wr  in  1  write strobe for the prescaler reload register.
- pre_din  in  WIDTH  prescaler reload value.
- div_wr  in  1  write strobe for the divider reload register.
- div_din  in  WIDTH  divider reload value.
- enable  in  1  level; timer runs while high.
- oneshot  in  1  level; 1 = stop after the first tick, 0 = periodic.
- irq_ack  in  1  interrupt acknowledge strobe.
- pre_q  out  WIDTH  current prescaler count.
- div_q  out  WIDTH  current divider count.
- running  out  1  high in state RUN.
- tick  out  1  one-cycle pulse on divider terminal count.
- irq  out  1  interrupt request.

Behaviour:
- Reset: state IDLE; pre_rld, div_rld, pre_q and div_q = 0; tick, irq and running = 0. Reset overrides every other input on the same edge.
- State IDLE:
  - enable=1 → on that edge pre_q<=pre_rld, div_q<=div_rld, go to RUN.
  - enable=0 → counts hold.
- State RUN, each edge:
  - pre_q!=0: pre_q<=pre_q-1.
  - pre_q==0 (prescaler borrow): pre_q<=pre_rld, and
    - div_q!=0: div_q<=div_q-1;
    - div_q==0: div_q<=div_rld, tick<=1 for one cycle, interrupt event raised.
  - Period = (pre_rld+1)*(div_rld+1) cycles. First tick is registered high the cycle after the edge ending the first period counted from the load edge.
  - pre_rld=div_rld=0: tick stays high every cycle.
  - Count wrap below 0 never occurs; the count reloads instead.
- One-shot: oneshot=1 at the terminal-count edge → state HALT instead of continuing. In HALT, counts hold their reloaded values and running=0.
- HALT → IDLE when enable=0.
- enable=0 in RUN → IDLE on that edge. Counts freeze; no tick fires on that edge even if it would have been terminal count.
- Re-enabling from IDLE always reloads both counts. There is no resume.
- Reload register writes:
  - pre_wr and div_wr update pre_rld and div_rld on the edge.
  - In IDLE or HALT, a write also loads the matching count directly.
  - In RUN, the new value takes effect at the next reload of that stage. A write and a reload on the same edge use the new din value.
  - Simultaneous pre_wr and div_wr are both honoured.
- irq: a one-cycle pulse coincident with tick (baseline; see Optional Feature).
- Latency: enable to first decrement = 1 edge after the load edge; terminal count to tick = 1 cycle (registered).

Optional Feature:
- Macro PIT_IRQ_LATCH_EN.
- Defined:
  - irq is a sticky level, set by the interrupt event and cleared by irq_ack on the edge.
  - If an event and irq_ack occur on the same edge, irq stays set.
  - Adds output ovr (1 bit, reset 0), set when an event occurs while irq is already 1, cleared with irq_ack unless another event occurs on the same edge.
- Not defined: irq is identical to tick, irq_ack is ignored, and ovr is absent.

Test Plan:
- Reset, write pre=2 and div=1 in IDLE, raise enable → counts (p,d) after successive edges: (2,1),(1,1),(0,1),(2,0),(1,0),(0,0),(2,1). tick high for the cycle following the 6th edge after load; repeats every 6 cycles.
- pre=0, div=0, periodic → tick and irq high every cycle while running; dropping enable → next cycle tick=0, running=0.
- oneshot=1, pre=1, div=2 → a single tick 6 cycles after load; state HALT with pre_q=1 and div_q=2; no further ticks; enable low then high restarts.
- In RUN with pre=3, write pre_din=1 mid-count → the current prescaler run completes from its existing count; the next reload loads 1. A write on the exact borrow edge loads the new value immediately.
- With PIT_IRQ_LATCH_EN defined, pre=0, div=1, no ack → irq set at the first tick and held; ovr=1 after the second tick; irq_ack → irq=0 and ovr=0 next cycle. An ack coincident with a tick leaves irq=1.
- Assert reset mid-RUN with pre_q=5 → next cycle all outputs and registers are 0 and the state is IDLE, regardless of enable or writes on that edge.
